// File: rtl/rr_stream_mux.sv
// Round-robin stream mux: raises arbiter requests from channel valids, latches the grant
// and forwards that channel's packet through tlast, optionally truncating at MAX_BEATS.
module rr_stream_mux #(
   parameter int unsigned  N         = 4,
   parameter int unsigned  DATA_W    = 32,
   parameter int unsigned  MAX_BEATS = 0,
   localparam int unsigned SEL_W     = (N > 1) ? $clog2(N) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N*DATA_W-1:0] in_tdata,
   input  logic [N-1:0]        in_tvalid,
   input  logic [N-1:0]        in_tlast,
   output logic [N-1:0]        in_tready,
   output logic [DATA_W-1:0]   out_tdata,
   output logic                out_tvalid,
   output logic                out_tlast,
   output logic [SEL_W-1:0]    out_tdest,
   input  logic                out_tready,
   output logic [N-1:0]        arb_req,
   input  logic [N-1:0]        arb_grant,
   output logic                busy,
   output logic                trunc_err
);

   localparam int unsigned CNT_W    = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
   localparam int unsigned LAST_CNT = (MAX_BEATS > 0) ? MAX_BEATS - 1 : 0;

   typedef enum logic [0:0] {StArb, StPass} state_e;

   // Lowest set bit wins, so a malformed multi-bit grant still selects one channel.
   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N-1:0] vec);
      onehot_to_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) onehot_to_idx = SEL_W'(i);
      end
   endfunction

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic              trunc_q, trunc_d;

   logic [DATA_W-1:0] sel_data;
   logic              sel_valid;
   logic              sel_last;
   logic              at_limit;
   logic              beat;

   always_comb begin
      sel_data  = in_tdata[int'(sel_q) * int'(DATA_W) +: DATA_W];
      sel_valid = in_tvalid[sel_q];
      sel_last  = in_tlast[sel_q];
      // Current beat is beat number MAX_BEATS of this grant.
      at_limit  = (MAX_BEATS != 0) && (beat_cnt_q == CNT_W'(LAST_CNT));
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      beat_cnt_d = beat_cnt_q;
      trunc_d    = 1'b0;
      arb_req    = '0;
      in_tready  = '0;
      out_tvalid = 1'b0;
      out_tlast  = 1'b0;
      out_tdata  = sel_data;
      beat       = 1'b0;

      unique case (state_q)
         StArb: begin
            // Masking on any grant bit stops the arbiter issuing a second grant.
            arb_req = (arb_grant == '0) ? in_tvalid : '0;
            if (arb_grant != '0) begin
               state_d    = StPass;
               sel_d      = onehot_to_idx(arb_grant);
               beat_cnt_d = '0;
            end
         end
         StPass: begin
            out_tvalid       = sel_valid;
            out_tlast        = sel_last | at_limit;
            in_tready[sel_q] = out_tready;
            beat             = sel_valid & out_tready;
            if (beat) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if (out_tlast) begin
                  state_d = StArb;
                  trunc_d = at_limit & ~sel_last;
               end
            end
         end
         default: state_d = StArb;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StArb;
         sel_q      <= '0;
         beat_cnt_q <= '0;
         trunc_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         beat_cnt_q <= beat_cnt_d;
         trunc_q    <= trunc_d;
      end
   end

   assign out_tdest = sel_q;
   assign busy      = (state_q == StPass);
   assign trunc_err = trunc_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux beside a behavioural round-robin arbiter; per-channel
// expected-beat queues are filled at push time and drained as beats leave the mux.
module tb_rr_stream_mux;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned MB = 4;

   typedef logic [DW:0] beat_t;  // {last, data}

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*DW-1:0] in_tdata;
   logic [N-1:0]    in_tvalid, in_tlast, in_tready;
   logic [DW-1:0]   out_tdata;
   logic            out_tvalid, out_tlast, out_tready;
   logic [1:0]      out_tdest;
   logic [N-1:0]    arb_req, arb_grant;
   logic            busy, trunc_err;

   int tests = 0;
   int fails = 0;
   int trunc_cnt = 0;
   int seq = 0;

   beat_t        src_q [N][$];
   beat_t        exp_q [N][$];
   int           grant_log [$];
   logic [N-1:0] hold;

   logic [N-1:0] s_req, s_grant, s_ready;
   logic         s_busy, s_valid, s_last, s_trunc;
   logic [1:0]   s_dest;

   always #5 clk = ~clk;

   rr_stream_mux #(
      .N         (N),
      .DATA_W    (DW),
      .MAX_BEATS (MB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_tdata   (in_tdata),
      .in_tvalid  (in_tvalid),
      .in_tlast   (in_tlast),
      .in_tready  (in_tready),
      .out_tdata  (out_tdata),
      .out_tvalid (out_tvalid),
      .out_tlast  (out_tlast),
      .out_tdest  (out_tdest),
      .out_tready (out_tready),
      .arb_req    (arb_req),
      .arb_grant  (arb_grant),
      .busy       (busy),
      .trunc_err  (trunc_err)
   );

   // Arbiter model: registered one-hot grant pulse, rotating priority.
   logic [N-1:0] grant_q;
   int           rr_ptr;
   assign arb_grant = grant_q;

   function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
      for (int i = 0; i < int'(N); i++) begin
         if (req[(ptr + i) % N]) return (ptr + i) % N;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         grant_q <= '0;
         rr_ptr  <= 0;
      end else if (rr_pick(arb_req, rr_ptr) >= 0) begin
         grant_q <= {{(N-1){1'b0}}, 1'b1} << rr_pick(arb_req, rr_ptr);
         rr_ptr  <= (rr_pick(arb_req, rr_ptr) + 1) % N;
      end else begin
         grant_q <= '0;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pending();
      int n = 0;
      for (int i = 0; i < int'(N); i++) n += exp_q[i].size();
      return n;
   endfunction

   task automatic drive();
      beat_t b;
      for (int i = 0; i < int'(N); i++) begin
         if (src_q[i].size() > 0) begin
            b = src_q[i][0];
            in_tdata[i*DW +: DW] = b[DW-1:0];
            in_tlast[i]          = b[DW];
            in_tvalid[i]         = !hold[i];
         end else begin
            in_tdata[i*DW +: DW] = '0;
            in_tlast[i]          = 1'b0;
            in_tvalid[i]         = 1'b0;
         end
      end
   endtask

   // Expected tlast: source tlast, or forced on every MB-th beat of an output packet.
   task automatic push_pkt(input int ch, input int len);
      int          pos = 1;
      logic        lst, xl;
      logic [31:0] dat;
      for (int k = 1; k <= len; k++) begin
         seq++;
         dat = 32'hA000_0000 | (32'(ch) << 24) | 32'(seq);
         lst = (k == len);
         xl  = lst || (pos == int'(MB));
         src_q[ch].push_back({lst, dat});
         exp_q[ch].push_back({xl, dat});
         pos = xl ? 1 : pos + 1;
      end
      drive();
   endtask

   task automatic tick();
      logic [N-1:0] hs, dmask;
      beat_t        e;
      int           d;
      @(negedge clk);
      s_req   = arb_req;
      s_grant = arb_grant;
      s_ready = in_tready;
      s_busy  = busy;
      s_valid = out_tvalid;
      s_last  = out_tlast;
      s_dest  = out_tdest;
      s_trunc = trunc_err;
      hs      = in_tvalid & in_tready;
      if (trunc_err) trunc_cnt++;
      if (arb_grant != '0) begin
         check("grant_onehot", 64'($onehot(arb_grant)), 1);
         check("grant_while_busy", busy, 0);
         for (int i = int'(N) - 1; i >= 0; i--) if (arb_grant[i]) d = i;
         grant_log.push_back(d);
      end
      d        = int'(out_tdest);
      dmask    = '0;
      dmask[d] = 1'b1;
      if (busy) check("tready_isolation", in_tready & ~dmask, 0);
      else      check("tready_idle", in_tready, 0);
      if (out_tvalid && out_tready) begin
         check("beat_src_handshake", hs, dmask);
         check("beat_pending", exp_q[d].size() > 0, 1);
         if (exp_q[d].size() > 0) begin
            e = exp_q[d].pop_front();
            check("beat_data_last", {out_tlast, out_tdata}, e);
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < int'(N); i++) begin
         if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      drive();
   endtask

   task automatic run_until_idle(input string tag, input int budget);
      int n = 0;
      do begin
         tick();
         n++;
      end while ((pending() != 0 || s_busy) && n < budget);
      check({tag, "_drained"}, pending(), 0);
   endtask

   task automatic wait_busy(input string tag, input int budget);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!s_busy && n < budget);
      check({tag, "_busy"}, s_busy, 1);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_req"}, s_req, 0);
      check({tag, "_tready"}, s_ready, 0);
      check({tag, "_tvalid"}, s_valid, 0);
      check({tag, "_tlast"}, s_last, 0);
      check({tag, "_tdest"}, s_dest, 0);
      check({tag, "_busy"}, s_busy, 0);
      check({tag, "_trunc"}, s_trunc, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      out_tready = 1'b1;
      hold       = '0;
      in_tdata   = '0;
      in_tvalid  = '0;
      in_tlast   = '0;
      drive();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_reset("reset");

      // All channels, two 2-beat packets each: strict 0,1,2,3 rotation.
      grant_log.delete();
      for (int p = 0; p < 2; p++)
         for (int ch = 0; ch < int'(N); ch++) push_pkt(ch, 2);
      run_until_idle("t2", 200);
      check("t2_grant_count", grant_log.size(), 8);
      for (int k = 0; k < grant_log.size(); k++) check("t2_grant_order", grant_log[k], k % 4);
      check("t2_no_trunc", trunc_cnt, 0);

      // Single channel timing.
      push_pkt(2, 3);
      tick();
      check("t1_req", s_req, 4'b0100);
      tick();
      check("t1_grant", s_grant, 4'b0100);
      check("t1_req_masked", s_req, 0);
      check("t1_idle_before_pass", s_busy, 0);
      tick();
      check("t1_beat1_valid", s_valid, 1);
      check("t1_beat1_dest", s_dest, 2);
      check("t1_beat1_last", s_last, 0);
      tick();
      check("t1_beat2_last", s_last, 0);
      tick();
      check("t1_beat3_last", s_last, 1);
      tick();
      check("t1_arb_busy", s_busy, 0);
      check("t1_arb_valid", s_valid, 0);
      check("t1_arb_dest_held", s_dest, 2);
      check("t1_drained", pending(), 0);

      // Backpressure on channel 1.
      push_pkt(1, 3);
      wait_busy("t3", 20);
      for (int k = 0; k < 4; k++) begin
         out_tready = (k >= 2);
         tick();
         check("t3_tready_track", s_ready, {2'b00, (k >= 2) ? 1'b1 : 1'b0, 1'b0});
         check("t3_valid", s_valid, 1);
      end
      out_tready = 1'b1;
      run_until_idle("t3", 50);

      // Valid gap: stay in PASS, no re-arbitration.
      grant_log.delete();
      push_pkt(0, 3);
      wait_busy("t6", 20);
      hold[0] = 1'b1;
      drive();
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t6_gap_busy", s_busy, 1);
         check("t6_gap_valid", s_valid, 0);
         check("t6_gap_req", s_req, 0);
      end
      hold[0] = 1'b0;
      drive();
      run_until_idle("t6", 50);
      check("t6_single_grant", grant_log.size(), 1);

      // Truncation at MB beats, remainder re-arbitrated.
      grant_log.delete();
      trunc_cnt = 0;
      push_pkt(3, 6);
      wait_busy("t4", 20);
      tick();
      tick();
      tick();
      check("t4_beat4_valid", s_valid, 1);
      check("t4_beat4_forced_last", s_last, 1);
      tick();
      check("t4_trunc_pulse", s_trunc, 1);
      check("t4_back_to_arb", s_busy, 0);
      run_until_idle("t4", 50);
      check("t4_trunc_once", trunc_cnt, 1);
      check("t4_grant_count", grant_log.size(), 2);
      for (int k = 0; k < grant_log.size(); k++) check("t4_grant_ch", grant_log[k], 3);

      // Reset mid-packet.
      trunc_cnt = 0;
      push_pkt(1, 4);
      wait_busy("t5", 20);
      tick();
      rst_n = 1'b0;
      src_q[1].delete();
      exp_q[1].delete();
      drive();
      tick();
      check("t5_mid_packet", s_busy, 1);
      rst_n = 1'b1;
      tick();
      check_reset("t5");
      push_pkt(1, 4);
      run_until_idle("t5_clean", 50);
      check("t5_no_trunc", trunc_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
